// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO-write bundle shared between the requesters, the FIFO write
// side and the round-robin write arbiter.
//   master : the arbiter (drives the FIFO write port and the acks)
//   slave  : the environment (requesters plus FIFO status flags)
interface fifo_wr_arbiter_if #(
    parameter int DSIZE = 8,
    parameter int NREQ  = 4
) ();
    logic [NREQ-1:0]         req;
    logic [NREQ*DSIZE-1:0]   req_data;
    logic [NREQ-1:0]         ack;
    logic                    wfull;
    logic                    tfull;
    logic                    winc;
    logic [DSIZE-1:0]        wdata;
    logic                    gnt_valid;
    logic [$clog2(NREQ)-1:0] gnt_id;
    logic [15:0]             words_wr;

    modport master (
        input  req, req_data, wfull, tfull,
        output ack, winc, wdata, gnt_valid, gnt_id, words_wr
    );

    modport slave (
        output req, req_data, wfull, tfull,
        input  ack, winc, wdata, gnt_valid, gnt_id, words_wr
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NREQ requesters.
// A grant lasts up to BURST words (1 word when the FIFO is 3/4 full at
// arbitration time), stalls on wfull, and ends early if the owner drops req.
// Write-side outputs are combinational from registered state, so an
// asynchronous reset removes winc/ack immediately.
module fifo_wr_arbiter #(
    parameter int DSIZE = 8,
    parameter int NREQ  = 4,
    parameter int BURST = 4
) (
    input  logic              wclk,
    input  logic              wrst,
    fifo_wr_arbiter_if.master bus
);
    localparam int             IDW       = $clog2(NREQ);
    localparam logic [7:0]     BURST_LIM = 8'(BURST);
    localparam logic [IDW-1:0] LAST_ID   = IDW'(NREQ - 1);
    localparam logic [IDW:0]   NREQ_W    = (IDW + 1)'(NREQ);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state_reg, state_next;
    logic [IDW-1:0] rr_ptr_reg, rr_ptr_next;
    logic [IDW-1:0] gnt_id_reg, gnt_id_next;
    logic [7:0]     burst_cnt_reg, burst_cnt_next;
    logic [7:0]     limit_reg, limit_next;
    logic [15:0]    words_wr_reg, words_wr_next;

    wire  [IDW-1:0]   cand_idx [NREQ];
    wire  [NREQ-1:0]  cand_req;
    wire  [DSIZE-1:0] req_word [NREQ];
    wire  [NREQ-1:0]  id_onehot;
    logic [IDW-1:0]   pick_idx;
    logic [IDW-1:0]   gnt_id_inc;
    logic             winc_int;
    logic             gnt_active;

    // Per-slot helpers: scan order starting at rr_ptr (explicit modulo so a
    // non-power-of-2 NREQ wraps correctly), word slices, one-hot of gnt_id.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slot
            wire [IDW:0] sum = {1'b0, rr_ptr_reg} + (IDW + 1)'(gi);
            wire [IDW:0] wrapped = sum - NREQ_W;
            assign cand_idx[gi]  = (sum >= NREQ_W) ? wrapped[IDW-1:0] : sum[IDW-1:0];
            assign cand_req[gi]  = bus.req[cand_idx[gi]];
            assign req_word[gi]  = bus.req_data[gi*DSIZE +: DSIZE];
            assign id_onehot[gi] = (gnt_id_reg == IDW'(gi));
        end
    endgenerate

    // Pick the first requesting slot in rotated order (slot 0 = rr_ptr).
    always_comb begin
        pick_idx = rr_ptr_reg;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                pick_idx = cand_idx[k];
            end
        end
    end

    // Pointer value that gives the just-finished owner lowest priority.
    always_comb begin
        gnt_id_inc = (gnt_id_reg == LAST_ID) ? '0 : gnt_id_reg + 1'b1;
    end

    // FIFO write port and acks, driven only while a grant is active.
    always_comb begin
        gnt_active    = (state_reg == GRANT);
        winc_int      = gnt_active & bus.req[gnt_id_reg] & ~bus.wfull;
        bus.winc      = winc_int;
        bus.gnt_valid = gnt_active;
        bus.wdata     = gnt_active ? req_word[gnt_id_reg] : '0;
        bus.ack       = winc_int ? id_onehot : '0;
        bus.gnt_id    = gnt_id_reg;
        bus.words_wr  = words_wr_reg;
    end

    // Next-state logic: arbitrate in IDLE, count/stall/finish bursts in GRANT.
    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        gnt_id_next    = gnt_id_reg;
        burst_cnt_next = burst_cnt_reg;
        limit_next     = limit_reg;
        words_wr_next  = words_wr_reg;

        if (winc_int && (words_wr_reg != 16'hFFFF)) begin
            words_wr_next = words_wr_reg + 16'd1;
        end

        case (state_reg)
            IDLE: begin
                if (|bus.req) begin
                    gnt_id_next    = pick_idx;
                    burst_cnt_next = '0;
                    limit_next     = bus.tfull ? 8'd1 : BURST_LIM;
                    state_next     = GRANT;
                end
            end
            GRANT: begin
                if (!bus.req[gnt_id_reg]) begin
                    state_next  = IDLE;
                    rr_ptr_next = gnt_id_inc;
                end else if (winc_int) begin
                    if (burst_cnt_reg == limit_reg - 8'd1) begin
                        state_next  = IDLE;
                        rr_ptr_next = gnt_id_inc;
                    end else begin
                        burst_cnt_next = burst_cnt_reg + 8'd1;
                    end
                end
                // wfull with req held: everything frozen, grant kept.
            end
            default: state_next = IDLE;
        endcase
    end

    // State register with asynchronous reset.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            gnt_id_reg    <= '0;
            burst_cnt_reg <= '0;
            limit_reg     <= BURST_LIM;
            words_wr_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            gnt_id_reg    <= gnt_id_next;
            burst_cnt_reg <= burst_cnt_next;
            limit_reg     <= limit_next;
            words_wr_reg  <= words_wr_next;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: directed phases followed by random traffic,
// every cycle compared against a grant-level reference model.
module tb_fifo_wr_arbiter;
    localparam int DSIZE = 8;
    localparam int NREQ  = 4;
    localparam int BURST = 4;

    logic wclk = 1'b0;
    logic wrst;

    fifo_wr_arbiter_if #(.DSIZE(DSIZE), .NREQ(NREQ)) bus ();

    fifo_wr_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .BURST(BURST)) dut (
        .wclk (wclk),
        .wrst (wrst),
        .bus  (bus)
    );

    always #5 wclk = ~wclk;

    int n_checks = 0;
    int n_fail   = 0;

    // Pending words per requester; req[i] is high while its queue is non-empty.
    logic [7:0] src_q [NREQ][$];
    // Log of words the DUT wrote (requester id from ack, data from wdata).
    int         log_id [$];
    logic [7:0] log_data [$];

    // Reference model: grant owner (-1 = arbitrating), where the next scan
    // starts, last granted id, words left in this grant, total words written.
    int m_owner = -1;
    int m_first = 0;
    int m_id    = 0;
    int m_left  = 0;
    int m_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_first = 0;
        m_id    = 0;
        m_left  = 0;
        m_total = 0;
    endtask

    // One clock cycle: drive at negedge, compare 1 time unit later, advance
    // model and sources at the posedge, return at the next negedge.
    task automatic step(input logic wf, input logic tf);
        logic [NREQ-1:0] r;
        logic [NREQ-1:0] am;
        logic            ew;
        logic [7:0]      ewd;
        logic            egv;
        int              eid;
        int              aid;
        for (int i = 0; i < NREQ; i++) begin
            bus.req[i] = (src_q[i].size() > 0);
            bus.req_data[i*DSIZE +: DSIZE] = (src_q[i].size() > 0) ? src_q[i][0] : 8'($urandom);
        end
        bus.wfull = wf;
        bus.tfull = tf;
        r = bus.req;
        #1;
        if (m_owner < 0) begin
            egv = 1'b0;
            eid = m_id;
            ew  = 1'b0;
            ewd = 8'h00;
        end else begin
            egv = 1'b1;
            eid = m_owner;
            ew  = r[m_owner] && !wf;
            ewd = bus.req_data[m_owner*DSIZE +: DSIZE];
        end
        check("gnt_valid", 32'(bus.gnt_valid), 32'(egv));
        check("gnt_id",    32'(bus.gnt_id),    32'(eid));
        check("winc",      32'(bus.winc),      32'(ew));
        check("wdata",     32'(bus.wdata),     32'(ewd));
        check("ack",       32'(bus.ack),       ew ? 32'(1) << eid : 32'd0);
        check("words_wr",  32'(bus.words_wr),  32'(m_total));
        am = bus.ack;
        if (bus.winc) begin
            aid = -1;
            for (int i = 0; i < NREQ; i++) begin
                if (am[i]) aid = i;
            end
            log_id.push_back(aid);
            log_data.push_back(bus.wdata);
            $display("wr t=%0t id=%0d data=%02h words_wr=%0d", $time, aid, bus.wdata, bus.words_wr);
        end
        @(posedge wclk);
        if (m_owner < 0) begin
            if (r != '0) begin
                for (int k = NREQ - 1; k >= 0; k--) begin
                    if (r[(m_first + k) % NREQ]) m_owner = (m_first + k) % NREQ;
                end
                m_id   = m_owner;
                m_left = tf ? 1 : BURST;
            end
        end else if (!r[m_owner]) begin
            m_first = (m_owner + 1) % NREQ;
            m_owner = -1;
        end else if (ew) begin
            if (m_total < 65535) m_total++;
            m_left--;
            if (m_left == 0) begin
                m_first = (m_owner + 1) % NREQ;
                m_owner = -1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (am[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        end
        @(negedge wclk);
    endtask

    // Assert reset between edges; outputs must drop at once.
    task automatic reset_mid();
        #2;
        wrst = 1'b1;
        #1;
        check("rst_winc",      32'(bus.winc),      32'd0);
        check("rst_ack",       32'(bus.ack),       32'd0);
        check("rst_gnt_valid", 32'(bus.gnt_valid), 32'd0);
        check("rst_words_wr",  32'(bus.words_wr),  32'd0);
        model_reset();
        @(negedge wclk);
        wrst = 1'b0;
    endtask

    initial begin
        int exp_thr [12] = '{2, 0, 2, 0, 2, 0, 0, 0, 0, 2, 2, 2};
        wrst         = 1'b1;
        bus.req      = '0;
        bus.req_data = '0;
        bus.wfull    = 1'b0;
        bus.tfull    = 1'b0;
        repeat (3) @(negedge wclk);
        check("reset_gnt_valid", 32'(bus.gnt_valid), 32'd0);
        check("reset_winc",      32'(bus.winc),      32'd0);
        check("reset_ack",       32'(bus.ack),       32'd0);
        check("reset_wdata",     32'(bus.wdata),     32'd0);
        check("reset_gnt_id",    32'(bus.gnt_id),    32'd0);
        check("reset_words_wr",  32'(bus.words_wr),  32'd0);
        wrst = 1'b0;

        // Idle after reset.
        repeat (10) step(1'b0, 1'b0);

        // Single requester, 8 words: two 4-word grants.
        for (int k = 0; k < 8; k++) src_q[2].push_back(8'hA0 + 8'(k));
        log_id.delete(); log_data.delete();
        repeat (12) step(1'b0, 1'b0);
        check("single_count", 32'(log_id.size()), 32'd8);
        for (int n = 0; n < log_id.size(); n++) begin
            check("single_id",   32'(log_id[n]),   32'd2);
            check("single_data", 32'(log_data[n]), 32'(8'hA0 + 8'(n)));
        end
        check("single_words_wr", 32'(bus.words_wr), 32'd8);

        // Round-robin, all four requesting 8 words; scan starts after id 2.
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k < 8; k++) src_q[i].push_back(8'(16 * (i + 1) + k));
        log_id.delete(); log_data.delete();
        repeat (42) step(1'b0, 1'b0);
        check("rr_count", 32'(log_id.size()), 32'd32);
        for (int n = 0; n < log_id.size(); n++) begin
            check("rr_id",   32'(log_id[n]),   32'((3 + n / 4) % 4));
            check("rr_data", 32'(log_data[n]), 32'(16 * (((3 + n / 4) % 4) + 1) + (n / 16) * 4 + n % 4));
        end

        // Back-pressure: 3-cycle wfull stall after the first word of req[1].
        for (int k = 0; k < 4; k++) src_q[1].push_back(8'hC0 + 8'(k));
        log_id.delete(); log_data.delete();
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b0);
        repeat (5) step(1'b0, 1'b0);
        check("bp_count", 32'(log_id.size()), 32'd4);
        check("bp_gnt_valid_after", 32'(bus.gnt_valid), 32'd0);

        // Throttle: tfull gives 1-word grants; tfull falling mid-grant keeps 1.
        for (int k = 0; k < 6; k++) begin
            src_q[0].push_back(8'h50 + 8'(k));
            src_q[2].push_back(8'h70 + 8'(k));
        end
        log_id.delete(); log_data.delete();
        repeat (8) step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        repeat (14) step(1'b0, 1'b0);
        check("thr_count", 32'(log_id.size()), 32'd12);
        for (int n = 0; n < log_id.size() && n < 12; n++) begin
            check("thr_id", 32'(log_id[n]), 32'(exp_thr[n]));
        end

        // Async reset after the 2nd word of a burst; then only req[3].
        for (int k = 0; k < 4; k++) src_q[2].push_back(8'hE0 + 8'(k));
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        reset_mid();
        src_q[2].delete();
        src_q[3].push_back(8'h33);
        src_q[3].push_back(8'h34);
        log_id.delete(); log_data.delete();
        repeat (5) step(1'b0, 1'b0);
        check("post_rst_count", 32'(log_id.size()), 32'd2);
        if (log_id.size() > 0) check("post_rst_first_id", 32'(log_id[0]), 32'd3);

        // Random traffic with random wfull/tfull and one mid-run reset.
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 9) == 0 && src_q[i].size() < 6) begin
                    int cnt = $urandom_range(1, 6);
                    for (int k = 0; k < cnt; k++) src_q[i].push_back(8'($urandom));
                end
            end
            if (c == 400) reset_mid();
            step(1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 2) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
